shift_add_mul: RTL and testbench

- Multi-cycle unsigned 16x16 shift-and-add multiplier; the multiplicative counterpart of the ALU's restoring divide/mod path.
- Uses the same start/done handshake and Z/N/C/V flag outputs as the divide/mod units, so the ALU control FSM sequences MUL identically to DIV/MOD.
- One iteration per clock; produces the full 32-bit product plus flags registered at completion.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/shift_add_dp.sv | 69 ++++++
 rtl/shift_add_mul.sv | 208 ++++++++++++++++++++
 tb/tb_shift_add_mul.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the multi-cycle arithmetic units (mul/div/mod).
//   MUL_WIDTH : default operand width of the shift-and-add multiplier.
//   state_e   : sequencing states; FIX is only reachable when the build
//               defines SHIFT_ADD_MUL_SIGNED_EN.
//   flags_t   : Z/N/C/V result flags, same layout as the div/mod units.
// ----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/shift_add_dp.sv
// ----------------------------------------------------------------------------
// shift_add_dp
// Datapath of the shift-and-add multiplier: multiplicand, accumulator and
// multiplier/low-product shift register, plus the add-then-shift step.
//
// Ports:
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   load           : capture mcand_in/mplier_in, clear the accumulator
//   step           : perform one add/shift iteration
//   mcand_in       : multiplicand to load
//   mplier_in      : multiplier to load
//   acc_nx         : accumulator value after this edge (next-state view)
//   mplier_nx      : multiplier/low-product value after this edge
//
// The "next" values are exported so the controller can register the final
// product on the same edge as the last iteration. When neither load nor step
// is active they equal the current register contents.
// ----------------------------------------------------------------------------
module shift_add_dp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic [WIDTH-1:0] acc_nx,
    output logic [WIDTH-1:0] mplier_nx
);

    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        // One extra bit keeps the carry of acc + mcand; it shifts into acc.
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        if (load) begin
            mcand_d  = mcand_in;
            mplier_d = mplier_in;
            acc_d    = '0;
        end else if (step) begin
            // {acc, mplier} <= {sum, mplier} >> 1
            acc_d    = sum[WIDTH:1];
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
        end
    end

    assign acc_nx    = acc_d;
    assign mplier_nx = mplier_d;

endmodule

// File: rtl/shift_add_mul.sv
// ----------------------------------------------------------------------------
// shift_add_mul
// Multi-cycle WIDTH x WIDTH shift-and-add multiplier, one iteration per clock,
// full 2*WIDTH product and Z/N/C/V flags registered at completion.
//
// Build option: SHIFT_ADD_MUL_SIGNED_EN
//   undefined : unsigned operands, WIDTH-cycle latency, V = C.
//   defined   : two's-complement operands; magnitudes are multiplied and a
//               FIX state negates the product when the signs differ
//               (latency WIDTH+1), C = 0, V = signed overflow of WIDTH bits.
//
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   start      : one-cycle request, sampled only in IDLE
//   a, b       : multiplicand, multiplier (only sampled on the accept edge)
//   result     : low half of the last completed product
//   result_hi  : high half of the last completed product
//   busy       : high from the cycle after accept until completion
//   done_mul   : one-cycle completion pulse
//   Z, N, C, V : flags of the last completed product
//   dbg_state  : current controller state
//
// Handshake: start is a request pulse, accepted on any edge where the state is
// IDLE (including the cycle done_mul is high); requests while busy are
// dropped, not queued. done_mul marks the single cycle in which result,
// result_hi and the flags first show the new product; those outputs then hold
// until the next completion or reset. Reset aborts an operation silently.
// ----------------------------------------------------------------------------
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done_mul,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output state_e           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    flags_t             flags_q,     flags_d;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    logic               neg_q,       neg_d;
`endif

    logic               dp_load;
    logic               dp_step;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]   mplier_nx;
    logic [2*WIDTH-1:0] fin;
    flags_t             fin_flags;
    logic               finish;

    shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (dp_load),
        .step      (dp_step),
        .mcand_in  (op_a),
        .mplier_in (op_b),
        .acc_nx    (acc_nx),
        .mplier_nx (mplier_nx)
    );

    // Operands handed to the datapath. In signed mode these are magnitudes;
    // -0x8000 wraps to 0x8000, which is the correct unsigned magnitude.
    always_comb begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
        op_a = a[WIDTH-1] ? -a : a;
        op_b = b[WIDTH-1] ? -b : b;
`else
        op_a = a;
        op_b = b;
`endif
    end

    // Final product and its flags, valid in the cycle finish is asserted.
    always_comb begin
        fin = {acc_nx, mplier_nx};
`ifdef SHIFT_ADD_MUL_SIGNED_EN
        if (neg_q) begin
            fin = -fin;
        end
        fin_flags.c = 1'b0;
        fin_flags.v = (fin[2*WIDTH-1:WIDTH] != {WIDTH{fin[WIDTH-1]}});
`else
        fin_flags.c = (fin[2*WIDTH-1:WIDTH] != '0);
        fin_flags.v = fin_flags.c;
`endif
        fin_flags.z = (fin[WIDTH-1:0] == '0);
        fin_flags.n = fin[WIDTH-1];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        dp_load     = 1'b0;
        dp_step     = 1'b0;
        finish      = 1'b0;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
        neg_d       = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dp_load = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                    neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                    state_d = FIX;
`else
                    finish  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            FIX: begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                // Datapath holds here, so acc_nx/mplier_nx are the magnitude.
                finish  = 1'b1;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            result_d    = fin[WIDTH-1:0];
            result_hi_d = fin[2*WIDTH-1:WIDTH];
            flags_d     = fin_flags;
            done_d      = 1'b1;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign busy      = busy_q;
    assign done_mul  = done_q;
    assign Z         = flags_q.z;
    assign N         = flags_q.n;
    assign C         = flags_q.c;
    assign V         = flags_q.v;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// ----------------------------------------------------------------------------
// tb_shift_add_mul
// Directed-vector bench for shift_add_mul. Expected products and flags are
// hand-computed for both the unsigned build and the SHIFT_ADD_MUL_SIGNED_EN
// build; the active set is selected at compile time.
// ----------------------------------------------------------------------------
module tb_shift_add_mul;
    import mul_pkg::*;

    localparam int W = 16;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif
    localparam int LAT = SGN ? 17 : 16;

    // ------------------------------------------------------------------
    // clock / reset / DUT
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         busy;
    logic         done_mul;
    logic         Z, N, C, V;
    state_e       dbg_state;

    always #5 clk = ~clk;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .busy      (busy),
        .done_mul  (done_mul),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // scoreboard
    // ------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // driver tasks (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_n++;
            if (done_mul) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [3:0] exp_f);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_lo"},    {16'd0, result},    {16'd0, e[15:0]});
            check({tag, "_hi"},    {16'd0, result_hi}, {16'd0, e[31:16]});
            check({tag, "_flags"}, {28'd0, Z, N, C, V}, {28'd0, exp_f});
        end
    endtask

    // Full transaction with latency/busy/done-width checks. Expected values
    // are given for both builds; flags are {Z,N,C,V}.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [31:0] pu, input logic [3:0] fu,
                          input logic [31:0] ps, input logic [3:0] fs);
        int lat;
        int bn;
        exp_q.push_back(SGN ? ps : pu);
        start_op(av, bv);
        check({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
        wait_done(lat, bn);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_cycles"}, bn, LAT - 1);
        check_result(tag, SGN ? fs : fu);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_drop"}, {31'd0, done_mul}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int bn;
        int pulses;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_lo",    {16'd0, result},    32'd0);
        check("rst_hi",    {16'd0, result_hi}, 32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_done",  {31'd0, done_mul},  32'd0);
        check("rst_flags", {28'd0, Z, N, C, V}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

        //      tag       a         b          unsigned prod  ZNCV     signed prod    ZNCV
        run_op("m3x5",   16'h0003, 16'h0005, 32'h0000_000F, 4'b0000, 32'h0000_000F, 4'b0000);
        run_op("mffff",  16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0011, 32'h0000_0001, 4'b0000);
        run_op("mzero",  16'h0000, 16'h1234, 32'h0000_0000, 4'b1000, 32'h0000_0000, 4'b1000);
        run_op("m100",   16'h0100, 16'h0100, 32'h0001_0000, 4'b1011, 32'h0001_0000, 4'b1001);
        run_op("mneg3",  16'hFFFD, 16'h0005, 32'h0004_FFF1, 4'b0111, 32'hFFFF_FFF1, 4'b0100);
        run_op("m8000",  16'h8000, 16'h8000, 32'h4000_0000, 4'b1011, 32'h4000_0000, 4'b1001);

        // Start while busy is ignored; outputs hold through the accept edge.
        exp_q.push_back(32'h0000_FFFF);
        start_op(16'h00FF, 16'h0101);
        check("ign_hold_lo", {16'd0, result},    32'h0000_0000);
        check("ign_hold_hi", {16'd0, result_hi}, 32'h0000_4000);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1;
        a     = 16'h0007;
        b     = 16'h0007;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        wait_done(lat, bn);
        check("ign_latency", lat, LAT - 5);
        check_result("ign", SGN ? 4'b0101 : 4'b0100);

        // Start in the done_mul cycle is accepted (back-to-back).
        exp_q.push_back(32'h0001_2340);
        start_op(16'h1234, 16'h0010);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bn);
        check("b2b_latency", lat, LAT);
        check_result("b2b", SGN ? 4'b0001 : 4'b0011);

        // Reset mid-operation aborts without a done pulse.
        @(posedge clk);
        @(negedge clk);
        start_op(16'h0009, 16'h0009);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_lo",    {16'd0, result},    32'd0);
        check("mrst_hi",    {16'd0, result_hi}, 32'd0);
        check("mrst_busy",  {31'd0, busy},      32'd0);
        check("mrst_done",  {31'd0, done_mul},  32'd0);
        check("mrst_flags", {28'd0, Z, N, C, V}, 32'd0);
        check("mrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        pulses = 0;
        repeat (24) begin
            @(posedge clk);
            @(negedge clk);
            if (done_mul) pulses++;
        end
        check("mrst_no_done", pulses, 0);

        run_op("after_rst", 16'h0010, 16'h0020, 32'h0000_0200, 4'b0000, 32'h0000_0200, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
